// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   Core-side initiator for a byte-addressable data memory. It accepts one
//   load/store request at a time from execute, rejects illegal or misaligned
//   accesses without touching memory, and issues a single-cycle read or write
//   strobe. It then waits out the memory latency, extends load data according
//   to the RISC-V funct3 width, and holds a single response until it is taken.
//
// Parameters
//   READ_LATENCY : cycles from mem_r_en high to valid mem_r_data (1..4)
//
// Ports
//   clk, rst_n             : clock, asynchronous active-low reset
//   req_valid/req_ready    : request handshake (ready only while idle)
//   req_we, req_funct3     : store flag, RISC-V width code
//   req_addr, req_wdata    : byte address, right-aligned store data
//   resp_valid/resp_ready  : response handshake
//   resp_rdata, resp_err   : extended load data, error code
//                            (00 ok, 01 misaligned, 10 memory fault, 11 illegal)
//   mem_r_*                : read strobe, address, mode, returned data
//   mem_w_*                : write strobe, address, data, mode
//   mem_state              : memory status, nonzero = fault
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic [1:0]  resp_err,
  output logic        mem_r_en,
  output logic [31:0] mem_r_addr,
  output logic [1:0]  mem_r_mode,
  input  logic [31:0] mem_r_data,
  output logic        mem_w_en,
  output logic [31:0] mem_w_addr,
  output logic [31:0] mem_w_data,
  output logic [3:0]  mem_w_mode,
  input  logic [1:0]  mem_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_FAULT = 2'b10;
  localparam logic [1:0] ERR_ILL   = 2'b11;

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic illegal, misaligned;

  // Width code in funct3[1:0]: 00 byte, 01 half, 10 word. funct3[2] marks
  // the unsigned load variants, which have no store counterpart.
  always_comb begin
    illegal    = !(req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                 || (req_we && req_funct3[2]);
    misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0])
                 || ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  extend = {{24{d[7]}}, d[7:0]};
      3'b001:  extend = {{16{d[15]}}, d[15:0]};
      3'b100:  extend = {24'h0, d[7:0]};
      3'b101:  extend = {16'h0, d[15:0]};
      default: extend = d;
    endcase
  endfunction

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          // Illegal encodings win over misalignment.
          if (illegal) begin
            err_d   = ERR_ILL;
            state_d = RESP;
          end else if (misaligned) begin
            err_d   = ERR_ALIGN;
            state_d = RESP;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        // Stores only need one cycle to sample mem_state.
        cnt_d   = we_q ? 3'd1 : 3'(READ_LATENCY);
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          if (mem_state != 2'b00) begin
            err_d   = ERR_FAULT;
            rdata_d = 32'h0;
          end else if (!we_q) begin
            rdata_d = extend(funct3_q, mem_r_data);
          end
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          rdata_d = 32'h0;
          err_d   = ERR_OK;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= 32'h0;
      wdata_q  <= 32'h0;
      cnt_q    <= 3'd0;
      rdata_q  <= 32'h0;
      err_q    <= ERR_OK;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Outputs are decoded from the state register so an asynchronous reset
  // drops strobes and response immediately.
  logic mem_active;
  assign mem_active = (state_q == ISSUE) || (state_q == WAIT);

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  assign mem_r_en   = (state_q == ISSUE) && !we_q;
  assign mem_r_addr = (mem_active && !we_q) ? addr_q : 32'h0;
  assign mem_r_mode = (mem_active && !we_q) ? funct3_q[1:0] : 2'b00;

  assign mem_w_en   = (state_q == ISSUE) && we_q;
  assign mem_w_addr = (mem_active && we_q) ? addr_q : 32'h0;
  assign mem_w_data = (mem_active && we_q) ? wdata_q : 32'h0;
  assign mem_w_mode = (mem_active && we_q) ? {2'b00, funct3_q[1:0]} : 4'b0000;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Core-side initiator for the byte-addressable data memory. It accepts one load or store request at a time from the execute stage through a valid/ready handshake.
- It decodes the RISC-V funct3 width, rejects misaligned or illegal accesses before they reach memory, and drives the memory read/write strobes for exactly one cycle.
- It waits out the memory read latency, sign- or zero-extends load data, and returns a single response with an error code.

Parameters:
READ_LATENCY, 1, cycles from mem_r_en high to valid mem_r_data; legal range 1..4

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit idle, can accept a request
req_we  input  1  1 = store, 0 = load
req_funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only)
req_addr  input  32  byte address
req_wdata  input  32  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer takes response
resp_rdata  output  32  extended load data; 0 for stores and errors
resp_err  output  2  00 OK, 01 misaligned, 10 memory fault, 11 illegal funct3
mem_r_en  output  1  memory read strobe
mem_r_addr  output  32  unmodified byte address
mem_r_mode  output  2  00 byte, 01 half, 10 word
mem_r_data  input  32  memory data, zero-extended, right-aligned
mem_w_en  output  1  memory write strobe
mem_w_addr  output  32  unmodified byte address
mem_w_data  output  32  req_wdata unshifted (memory performs lane shift)
mem_w_mode  output  4  {2'b00, width code}
mem_state  input  2  memory status; 00 = OK, any other value = fault

Behaviour:
- Reset (async, rst_n=0):
  - state IDLE.
  - resp_valid=0, resp_rdata=0, resp_err=00.
  - mem_r_en=0, mem_w_en=0.
  - All mem address, data and mode outputs = 0.
  - Wait counter = 0.
  - Reset asserted mid-operation aborts immediately; the pending request is lost and no strobe remains high.
- req_ready=1 exactly when the state is IDLE.
- A request is accepted in the cycle where req_valid&&req_ready; address, data, width and we are registered at that point.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE -> RESP when any of the following holds; no memory strobe is issued and resp_err is set:
  - funct3 not in {000,001,010,100,101} -> resp_err=11.
  - Store with funct3 in {100,101} -> resp_err=11.
  - Half access with addr[0]=1 -> resp_err=01.
  - Word access with addr[1:0]!=0 -> resp_err=01.
  - Illegal takes priority over misaligned.
- IDLE -> ISSUE for all other accepted requests.
- ISSUE (1 cycle):
  - Load: mem_r_en=1. Store: mem_w_en=1.
  - Addr/mode/data outputs hold the registered values from ISSUE through the end of WAIT.
  - Counter loads READ_LATENCY for a load, 1 for a store. Next state WAIT.
- WAIT:
  - Both strobes 0; counter decrements each cycle.
  - In the cycle the counter reads 1:
    - Capture mem_state; nonzero -> resp_err=10 and resp_rdata=0.
    - Else for a load, capture mem_r_data and extend: B sign-extends bit 7, H sign-extends bit 15, W passes through, BU/HU zero-extend.
    - Next state RESP.
- RESP:
  - resp_valid=1; resp_rdata/resp_err held stable until resp_ready=1.
  - On resp_ready: resp_valid drops the next cycle, state returns to IDLE, resp_rdata and resp_err clear to 0.
  - No back-to-back acceptance in the RESP cycle.
- Latency, valid access accepted at cycle T with resp_ready tied high:
  - Strobe at T+1.
  - resp_valid at T+2+READ_LATENCY for loads, T+3 for stores.
- Latency for rejected requests: resp_valid at T+1.
- Strobes are never high in the same cycle, and never high for more than one cycle per request.
- Any address is legal; wrap at 0xFFFFFFFF is not special-cased. Address alignment to words is the memory's job.

Test Plan:
- Load word, addr 0x10, mem_r_data=0xDEADBEEF, READ_LATENCY=1, accept at T -> mem_r_en only at T+1 with mem_r_mode=10; resp_valid at T+3 with rdata 0xDEADBEEF, err 00.
- Byte load: LB addr 0x13, mem_r_data=0x00000080 -> rdata 0xFFFFFF80. LBU same -> 0x00000080. LH addr 0x12, data 0x00008001 -> 0xFFFF8001.
- SW addr 0x06 -> no mem_w_en ever, resp_valid at T+1, err 01. LH addr 0x01 -> err 01. Store funct3=100 -> err 11. funct3=011 load -> err 11.
- SB addr 0x21, wdata 0x000000AB -> mem_w_en one cycle at T+1, mem_w_addr 0x21, mem_w_mode 0000, mem_w_data 0xAB; resp at T+3, err 00. Same with mem_state=01 during WAIT -> err 10.
- resp_ready low for 3 cycles during RESP -> resp_valid, rdata, err stable; req_ready=0 and new req_valid ignored. Then READ_LATENCY=3 load -> resp at T+5.
- Assert rst_n=0 in the ISSUE cycle -> mem_r_en and resp_valid fall immediately; after release, req_ready=1 and the next load completes normally.
